// File: rtl/axi_frame_tagger.sv
// Framing stage ahead of the channelizer FIFO: tags samples with their in-frame index,
// marks frame ends with tlast, and only starts a frame when the FIFO is not almost full.
module axi_frame_tagger #(
  parameter int DATA_WIDTH  = 32,
  parameter int TUSER_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   sync_reset,
  input  logic [TUSER_WIDTH-1:0] frame_len_m1,
  input  logic                   s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic                   s_axis_tlast,
  output logic                   s_axis_tready,
  output logic                   m_axis_tvalid,
  output logic [DATA_WIDTH-1:0]  m_axis_tdata,
  output logic                   m_axis_tlast,
  output logic [TUSER_WIDTH-1:0] m_axis_tuser,
  input  logic                   m_axis_tready,
  input  logic                   m_axis_almost_full,
  output logic                   frame_err
);

  typedef enum logic {IDLE, RUN} state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]  data;
    logic [TUSER_WIDTH-1:0] user;
    logic                   last;
  } beat_t;

  state_t                 state_q, state_d;
  logic [TUSER_WIDTH-1:0] len_q, len_d;
  logic [TUSER_WIDTH-1:0] cnt_q, cnt_d;
  beat_t                  main_q, main_d, skid_q, skid_d;
  logic                   main_vld_q, main_vld_d;
  logic                   skid_vld_q, skid_vld_d;
  logic                   rdy_q, rdy_d;
  logic                   err_q, err_d;

  logic                   acc, drain, hit;
  logic [TUSER_WIDTH-1:0] idx, eff_len;
  beat_t                  in_beat;

  always_comb begin
    acc     = s_axis_tvalid & rdy_q;
    drain   = main_vld_q & m_axis_tready;
    // In IDLE the live frame_len_m1 governs the first sample of the new frame.
    eff_len = (state_q == IDLE) ? frame_len_m1 : len_q;
    idx     = (state_q == IDLE) ? '0 : cnt_q;
    hit     = (idx == eff_len);

    in_beat.data = s_axis_tdata;
    in_beat.user = idx;
    in_beat.last = hit | s_axis_tlast;

    state_d    = state_q;
    len_d      = eff_len;
    cnt_d      = cnt_q;
    main_d     = main_q;
    main_vld_d = main_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    err_d      = acc & s_axis_tlast & ~hit;

    if (acc) begin
      if (in_beat.last) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        state_d = RUN;
        cnt_d   = idx + TUSER_WIDTH'(1);
      end
    end

    // Accept is impossible while skid is occupied (rdy_q tracks skid empty).
    if (drain || !main_vld_q) begin
      if (skid_vld_q) begin
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_vld_d = 1'b0;
      end else if (acc) begin
        main_d     = in_beat;
        main_vld_d = 1'b1;
      end else begin
        main_vld_d = 1'b0;
      end
    end else if (acc) begin
      skid_d     = in_beat;
      skid_vld_d = 1'b1;
    end

    rdy_d = ~skid_vld_d & ((state_d == RUN) | ~m_axis_almost_full);
  end

  always_ff @(posedge clk) begin
    if (!sync_reset) begin
      state_q    <= IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      main_q     <= '0;
      main_vld_q <= 1'b0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
      rdy_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      main_q     <= main_d;
      main_vld_q <= main_vld_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
      rdy_q      <= rdy_d;
      err_q      <= err_d;
    end
  end

  assign s_axis_tready = rdy_q;
  assign m_axis_tvalid = main_vld_q;
  assign m_axis_tdata  = main_q.data;
  assign m_axis_tuser  = main_q.user;
  assign m_axis_tlast  = main_q.last;
  assign frame_err     = err_q;

endmodule

// File: doc/axi_frame_tagger.md
Name: axi_frame_tagger

Overview:
- Stream framing stage that sits directly upstream of the channelizer's AXI FIFO and feeds its s_axis port.
- Counts input samples into frames of a programmable length and tags each sample with its in-frame index on tuser.
- Asserts tlast on the final sample of each frame.
- Gates frame starts on the downstream FIFO's almost_full, so a frame is never begun unless the FIFO has room to absorb it.

Parameters:
- DATA_WIDTH, 32, width of sample data.
- TUSER_WIDTH, 8, width of the in-frame index; maximum frame length is 2^TUSER_WIDTH.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- sync_reset  input  1  reset, synchronous and active-low: sampled low at a rising clk edge resets the block.
- frame_len_m1  input  TUSER_WIDTH  frame length minus one; sampled only at frame start.
- s_axis_tvalid  input  1  upstream sample valid.
- s_axis_tdata  input  DATA_WIDTH  upstream sample.
- s_axis_tlast  input  1  upstream frame marker; used only for resync/error detection.
- s_axis_tready  output  1  block can accept a sample.
- m_axis_tvalid  output  1  output sample valid.
- m_axis_tdata  output  DATA_WIDTH  sample, passed unchanged.
- m_axis_tlast  output  1  high on index == latched frame_len_m1.
- m_axis_tuser  output  TUSER_WIDTH  in-frame index, 0..frame_len_m1.
- m_axis_tready  input  1  downstream ready.
- m_axis_almost_full  input  1  downstream FIFO almost_full.
- frame_err  output  1  one-cycle pulse on an upstream tlast mismatch.

Behaviour:
- Reset (sync_reset low at clk edge): state = IDLE, index = 0, both skid entries empty.
  - Outputs: m_axis_tvalid = 0, m_axis_tlast = 0, m_axis_tuser = 0, m_axis_tdata = 0, frame_err = 0, s_axis_tready = 0.
  - Reset mid-frame discards any partial frame and all held samples; no tlast is emitted for it.
- Output path: 2-entry skid buffer (main + skid registers).
  - s_axis_tready is registered and equals "skid entry empty" AND (state == RUN, or state == IDLE with m_axis_almost_full low).
  - Latency from an accepted input to m_axis_tvalid is 1 cycle.
  - Sustains 1 sample/clk when m_axis_tready is held high.
  - Output registers hold stable while m_axis_tvalid = 1 and m_axis_tready = 0 (AXI rule).
  - Ordering is preserved through the skid entry.
- State machine:
  - IDLE: latch len = frame_len_m1 every cycle. The block accepts when s_axis_tvalid & s_axis_tready, and s_axis_tready in IDLE requires m_axis_almost_full low. On an accepted sample, tag index 0 and go to RUN. If len == 0 the sample carries tlast = 1 and the state stays IDLE.
  - RUN: each accepted sample is tagged with index = count, and count increments. The sample with count == len carries tlast = 1, count returns to 0, and the state goes to IDLE. almost_full is ignored in RUN, so a started frame always completes.
- frame_len_m1 changes mid-frame have no effect until the next IDLE.
- Resync (evaluated on accepted samples only):
  - Upstream s_axis_tlast = 1 on a sample whose index != len: frame_err pulses for 1 cycle, the sample is emitted with tlast = 1 (frame truncated), and the state goes to IDLE.
  - Index == len with s_axis_tlast = 0 is not an error; s_axis_tlast is advisory.
- Counter: TUSER_WIDTH bits, no wrap beyond len. With len = 2^TUSER_WIDTH-1 the index runs to all-ones and tlast is set there.
- Simultaneous input accept and output drain in the same cycle: the main register reloads directly; the skid entry is used only when the output is stalled.

Test Plan:
- frame_len_m1 = 3, tvalid and tready held high, data 0..11 -> outputs tuser 0,1,2,3 repeating, tlast on data 3, 7, 11; one beat per clk after 1-cycle latency.
- Same setup, m_axis_tready toggling 1,0,0,1 -> no sample lost or duplicated, outputs stable while stalled, s_axis_tready drops within 1 cycle of the skid filling.
- m_axis_almost_full = 1 in IDLE with tvalid high -> s_axis_tready = 0 and no output. Deassert -> frame starts with tuser 0. Assert almost_full mid-frame (len 7) -> all 8 samples still complete.
- len = 7, upstream s_axis_tlast on the 5th sample (index 4) -> that output has tlast = 1 and tuser = 4, frame_err pulses once, next sample has tuser 0.
- frame_len_m1 = 0 -> every output has tuser 0 and tlast 1. Change frame_len_m1 to 2 mid-frame under len 5 -> the current frame still ends at index 5.
- Drive sync_reset low for 1 cycle with 3 of 8 samples emitted and the output stalled -> m_axis_tvalid = 0 next cycle; the next accepted sample has tuser 0.
